// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared encodings for the LED pattern generator
//
// Purpose: mode select encodings and the BOUNCE direction type used by
//          led_pattern_gen and the bench.
// Ports:   none (package).
package led_pkg;

  localparam logic [1:0] MODE_FILL   = 2'b00;
  localparam logic [1:0] MODE_RUN    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_tick_div.sv
// rtl/led_tick_div.sv - pausable prescaler producing one tick per TICK_DIV cycles
//
// Purpose: counts 0..TICK_DIV-1 while pause=0 and flags the terminal count
//          as tick. clr restarts the count from zero and wins over pause.
// Ports:   clk   - clock
//          rst_n - asynchronous active-low reset
//          clr   - synchronous clear of the count
//          pause - 1 holds the count and masks tick
//          tick  - combinational, high in the cycle cnt==TICK_DIV-1 and pause=0
module led_tick_div #(
  parameter int unsigned TICK_DIV = 25000000,
  parameter int          CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic pause,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !pause && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - WIDTH-bit LED pattern generator with four runtime modes
//
// Purpose: steps a FILL / RUN / BOUNCE / BLINK pattern once every TICK_DIV
//          clocks. A change on mode reloads the new mode's seed and restarts
//          the prescaler; pause freezes both.
// Build option: LED_ACTIVE_LOW_EN defined inverts the led port for LEDs wired
//          to VCC (reset then lights every LED). Undefined: active-high.
// Ports:   clk   - board clock
//          rst_n - asynchronous active-low reset
//          mode  - 00 FILL, 01 RUN, 10 BOUNCE, 11 BLINK
//          pause - 1 freezes prescaler and pattern
//          led   - registered LED drive
//          step  - one-cycle strobe in the cycle a tick-driven value appears
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter int unsigned TICK_DIV = 25000000,
  parameter int          CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic [WIDTH-1:0] led,
  output logic             step
);

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       mode_q;
  dir_t             dir_q, dir_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             step_d;
  logic             reload;
  logic             tick;

  // Any difference between the live and registered mode is a mode change;
  // it also catches a non-FILL mode present when reset releases.
  assign reload = (mode != mode_q);

  led_tick_div #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (reload),
    .pause (pause),
    .tick  (tick)
  );

  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    return (m == MODE_RUN || m == MODE_BOUNCE) ? ONE : ONES;
  endfunction

  always_comb begin
    pat_d  = pat_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (reload) begin
      // Reload wins over a coincident tick, so no step is reported.
      pat_d = seed(mode);
      dir_d = DIR_UP;
    end else if (tick) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_FILL: pat_d = (pat_q == '0) ? ONES : (pat_q << 1);
        MODE_RUN:  pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        MODE_BOUNCE: begin
          // Turn around on the same tick that reaches an end, so the end
          // position is shown for exactly one step.
          if (dir_q == DIR_UP) begin
            if (pat_q[WIDTH-1]) begin
              dir_d = DIR_DOWN;
              pat_d = pat_q >> 1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DIR_UP;
              pat_d = pat_q << 1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        default:   pat_d = ~pat_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_FILL;
      dir_q  <= DIR_UP;
      pat_q  <= ONES;
      step   <= 1'b0;
    end else begin
      mode_q <= mode;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      step   <= step_d;
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~pat_q;
`else
  assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen
module tb_led_pattern_gen;
  import led_pkg::*;

  localparam int W  = 4;
  localparam int TD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode_in = MODE_FILL;
  logic         pause_in = 1'b0;
  logic [W-1:0] led;
  logic         step;

  led_pattern_gen #(.WIDTH(W), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode_in),
    .pause (pause_in),
    .led   (led),
    .step  (step)
  );

  always #5 clk = ~clk;

  // Reference model: a pattern is a cyclic list indexed by m_k; m_cnt counts
  // unpaused cycles since the last step or reload.
  logic [1:0]   m_mode = MODE_FILL;
  int           m_k = 0;
  int           m_cnt = 0;
  logic         m_step = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ones = '1;
  logic [W-1:0] e;
  logic [W-1:0] held;
  int           total = 0;
  int           bad = 0;
  bit           chk_on = 1'b0;

  function automatic logic [W-1:0] pat(input logic [1:0] md, input int k);
    logic [W-1:0] all1;
    all1 = '1;
    case (md)
      MODE_FILL:   return (k < W) ? (all1 << k) : '0;
      MODE_RUN:    return W'(1) << k;
      MODE_BOUNCE: return (k < W) ? (W'(1) << k) : (W'(1) << (2*(W-1) - k));
      default:     return (k % 2 == 0) ? all1 : '0;
    endcase
  endfunction

  function automatic int period(input logic [1:0] md);
    case (md)
      MODE_FILL:   return W + 1;
      MODE_RUN:    return W;
      MODE_BOUNCE: return 2*W - 2;
      default:     return 2;
    endcase
  endfunction

  function automatic logic [W-1:0] to_port(input logic [W-1:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_step = 1'b0;
    if (mode_in != m_mode) begin
      m_mode = mode_in;
      m_k    = 0;
      m_cnt  = 0;
    end else if (!pause_in) begin
      if (m_cnt == TD - 1) begin
        m_cnt  = 0;
        m_k    = (m_k + 1) % period(m_mode);
        m_step = 1'b1;
        exp_q.push_back(pat(m_mode, m_k));
      end else begin
        m_cnt++;
      end
    end
  endtask

  // Apply inputs, take one edge, advance the model; returns at edge+1.
  task automatic tick_cycle(input logic [1:0] md, input logic ps);
    mode_in  = md;
    pause_in = ps;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Called at edge+1; asserts reset between edges.
  task automatic do_async_reset();
    #6;
    rst_n = 1'b0;
    #1;
    check("async_led", led, to_port(ones));
    check("async_step", step, 0);
    check("queue_empty_at_reset", exp_q.size(), 0);
    m_mode = MODE_FILL;
    m_k    = 0;
    m_cnt  = 0;
    m_step = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle tracking plus scoreboard pop on every DUT step.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("led_track", led, to_port(pat(m_mode, m_k)));
      check("step_track", step, m_step);
      if (step) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL step_unexpected: got step=1 expected no step at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("step_led", led, to_port(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int n;
    logic [1:0] md;
    logic ps;

    repeat (3) @(posedge clk);
    #1;
    check("reset_led", led, to_port(ones));
    check("reset_step", step, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // FILL from reset release: first step on edge 4.
    first = 0;
    for (int i = 1; i <= 24; i++) begin
      tick_cycle(MODE_FILL, 1'b0);
      if (step && first == 0) first = i;
    end
    check("first_step_edge", first, 4);

    // RUN
    tick_cycle(MODE_RUN, 1'b0);
    check("run_seed_led", led, to_port(W'(1)));
    check("run_seed_step", step, 0);
    repeat (20) tick_cycle(MODE_RUN, 1'b0);

    // BOUNCE, then reset while travelling down
    repeat (30) tick_cycle(MODE_BOUNCE, 1'b0);
    n = 0;
    while (!(m_k >= W) && n < 50) begin
      tick_cycle(MODE_BOUNCE, 1'b0);
      n++;
    end
    check("bounce_down_reached", (m_k >= W) ? 1 : 0, 1);
    do_async_reset();
    repeat (12) tick_cycle(MODE_BOUNCE, 1'b0);

    // BLINK with pause mid-count
    tick_cycle(MODE_BLINK, 1'b0);
    repeat (2) tick_cycle(MODE_BLINK, 1'b0);
    held = led;
    for (int i = 0; i < 10; i++) begin
      tick_cycle(MODE_BLINK, 1'b1);
      check("pause_hold_led", led, held);
      check("pause_no_step", step, 0);
    end
    first = 0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      tick_cycle(MODE_BLINK, 1'b0);
      if (step) first = i;
    end
    check("pause_resume_edges", first, 2);
    check("pause_resume_led", led, to_port('0));

    // Mode change on the terminal count cycle
    tick_cycle(MODE_FILL, 1'b0);
    n = 0;
    while (m_cnt != TD - 1 && n < 10) begin
      tick_cycle(MODE_FILL, 1'b0);
      n++;
    end
    tick_cycle(MODE_RUN, 1'b0);
    check("chg_no_step", step, 0);
    check("chg_seed_led", led, to_port(W'(1)));
    first = 0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      tick_cycle(MODE_RUN, 1'b0);
      if (step) first = i;
    end
    check("chg_next_step_edges", first, TD);

    // Randomized run
    md = MODE_RUN;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
      ps = ($urandom_range(0, 3) == 0);
      tick_cycle(md, ps);
      if ($urandom_range(0, 499) == 0) do_async_reset();
    end

    repeat (4) tick_cycle(md, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
